// File: rtl/tmu2_pkg.sv
// Shared definitions for the TMU2 vertex fetch stage: coordinate widths,
// WISHBONE cycle-type codes, vertex word offsets, read sequencing and FSM states.
package tmu2_pkg;

  localparam int TEX_W = 18;
  localparam int DST_W = 12;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;

  // Byte offset of each 32-bit word within an 8-byte vertex record
  localparam logic [3:0] WORD_X_OFS = 4'd0;
  localparam logic [3:0] WORD_Y_OFS = 4'd4;

  // Read slot index: bit2 = row+1, bit1 = col+1, bit0 = Y word
  localparam logic [2:0] RD_FIRST       = 3'd0;
  localparam logic [2:0] RD_REUSE_FIRST = 3'd2;
  localparam logic [2:0] RD_BY          = 3'd3;
  localparam logic [2:0] RD_DX          = 3'd6;
  localparam logic [2:0] RD_LAST        = 3'd7;

  typedef logic signed [TEX_W-1:0] tex_t;
  typedef logic signed [DST_W-1:0] dst_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_OUTPUT,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tmu2_fetchvertex_if.sv
// Memory-side WISHBONE master plus the token bus towards interpolation.
// master = fetch stage, slave = memory/downstream side.
interface tmu2_fetchvertex_if;
  import tmu2_pkg::*;

  logic [31:0] wbm_adr_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  logic        pipe_stb_o;
  logic        pipe_ack_i;
  tex_t        ax, ay, bx, by, cx, cy, dx, dy;
  dst_t        drx, dry;

  modport master (
    output wbm_adr_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_ack_i, wbm_dat_i,
    output pipe_stb_o,
    input  pipe_ack_i,
    output ax, ay, bx, by, cx, cy, dx, dy, drx, dry
  );

  modport slave (
    input  wbm_adr_o, wbm_cti_o, wbm_cyc_o, wbm_stb_o,
    output wbm_ack_i, wbm_dat_i,
    input  pipe_stb_o,
    output pipe_ack_i,
    input  ax, ay, bx, by, cx, cy, dx, dy, drx, dry
  );

endinterface

// File: rtl/tmu2_fetchvertex_addr.sv
// Combinational vertex byte-address generator: base + ((row<<stride)+col)*8 + word*4,
// wrapping modulo 2^32.
module tmu2_fetchvertex_addr
  import tmu2_pkg::*;
#(
  parameter int stride_log2 = 7
) (
  input  logic [28:0] vertex_adr,
  input  logic [6:0]  row,
  input  logic [6:0]  col,
  input  logic        word,
  output logic [31:0] adr
);

  logic [31:0] vtx_idx;
  logic [31:0] vtx_ofs;

  always_comb begin
    vtx_idx = ({25'd0, row} << stride_log2) + {25'd0, col};
    vtx_ofs = (vtx_idx << 3) + {28'd0, (word ? WORD_Y_OFS : WORD_X_OFS)};
    adr     = {vertex_adr, 3'b000} + vtx_ofs;
  end

endmodule

// File: rtl/tmu2_fetchvertex.sv
// Walks the vertex mesh, reads four corners per square over WISHBONE and emits one token per square.
// Optional TMU2_FETCHVERTEX_REUSE_EN: reuse right-hand corners when stepping along a row.
module tmu2_fetchvertex
  import tmu2_pkg::*;
#(
  parameter int stride_log2 = 7
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              busy,
  input  logic [6:0]        vertex_hlast,
  input  logic [6:0]        vertex_vlast,
  input  logic [28:0]       vertex_adr,
  input  logic [DST_W-1:0]  dst_hoffset,
  input  logic [DST_W-1:0]  dst_voffset,
  input  logic [10:0]       dst_squarew,
  input  logic [10:0]       dst_squareh,
  tmu2_fetchvertex_if.master bus
);

`ifdef TMU2_FETCHVERTEX_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif

  state_t      state, state_nxt;
  logic [6:0]  x, y;
  logic [2:0]  rd_idx;
  logic        reuse;
  tex_t        ax, ay, bx, by, cx, cy, dx, dy;
  dst_t        drx, dry;
  logic        wb_cyc, pipe_stb;

  logic [7:0]  x_inc, y_inc;
  logic        row_more, last_row, mesh_empty;
  logic [6:0]  rd_row, rd_col;
  logic [31:0] rd_adr;
  tex_t        rd_dat;
  logic        unused_dat_hi;

  assign x_inc      = {1'b0, x} + 8'd1;
  assign y_inc      = {1'b0, y} + 8'd1;
  assign row_more   = x_inc < {1'b0, vertex_hlast};
  assign last_row   = y_inc == {1'b0, vertex_vlast};
  assign mesh_empty = (vertex_hlast == 7'd0) || (vertex_vlast == 7'd0);

  assign rd_row        = y + {6'd0, rd_idx[2]};
  assign rd_col        = x + {6'd0, rd_idx[1]};
  assign rd_dat        = bus.wbm_dat_i[TEX_W-1:0];
  assign unused_dat_hi = ^bus.wbm_dat_i[31:TEX_W];

  tmu2_fetchvertex_addr #(
    .stride_log2 (stride_log2)
  ) u_addr (
    .vertex_adr (vertex_adr),
    .row        (rd_row),
    .col        (rd_col),
    .word       (rd_idx[0]),
    .adr        (rd_adr)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = mesh_empty ? ST_DONE : ST_FETCH;
      ST_FETCH:  if (bus.wbm_ack_i && rd_idx == RD_LAST) state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (bus.pipe_ack_i) state_nxt = ST_NEXT;
      ST_NEXT:   state_nxt = (!row_more && last_row) ? ST_DONE : ST_FETCH;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != ST_IDLE);
    wb_cyc   = (state == ST_FETCH);
    pipe_stb = (state == ST_OUTPUT);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x <= '0; y <= '0; rd_idx <= RD_FIRST; reuse <= 1'b0;
      drx <= '0; dry <= '0;
      ax <= '0; ay <= '0; bx <= '0; by <= '0;
      cx <= '0; cy <= '0; dx <= '0; dy <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          x <= '0; y <= '0; rd_idx <= RD_FIRST; reuse <= 1'b0;
          drx <= dst_hoffset; dry <= dst_voffset;
        end
        ST_FETCH: if (bus.wbm_ack_i) begin
          case (rd_idx)
            3'd0: ax <= rd_dat;
            3'd1: ay <= rd_dat;
            3'd2: bx <= rd_dat;
            3'd3: by <= rd_dat;
            3'd4: cx <= rd_dat;
            3'd5: cy <= rd_dat;
            3'd6: dx <= rd_dat;
            3'd7: dy <= rd_dat;
          endcase
          // A reused square skips C after fetching B
          rd_idx <= (reuse && rd_idx == RD_BY) ? RD_DX : rd_idx + 3'd1;
        end
        ST_NEXT: begin
          if (row_more) begin
            x   <= x_inc[6:0];
            drx <= drx + {1'b0, dst_squarew};
            if (REUSE_EN) begin
              ax <= bx; ay <= by; cx <= dx; cy <= dy;
              rd_idx <= RD_REUSE_FIRST; reuse <= 1'b1;
            end else begin
              rd_idx <= RD_FIRST; reuse <= 1'b0;
            end
          end else begin
            x <= '0; drx <= dst_hoffset;
            y <= y_inc[6:0]; dry <= dry + {1'b0, dst_squareh};
            rd_idx <= RD_FIRST; reuse <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wbm_adr_o  = wb_cyc ? rd_adr : 32'd0;
  assign bus.wbm_cti_o  = WB_CTI_CLASSIC;
  assign bus.wbm_cyc_o  = wb_cyc;
  assign bus.wbm_stb_o  = wb_cyc;
  assign bus.pipe_stb_o = pipe_stb;
  assign bus.ax = ax; assign bus.ay = ay;
  assign bus.bx = bx; assign bus.by = by;
  assign bus.cx = cx; assign bus.cy = cy;
  assign bus.dx = dx; assign bus.dy = dy;
  assign bus.drx = drx; assign bus.dry = dry;

endmodule

// File: tb/tb_tmu2_fetchvertex.sv
// Randomized bench for tmu2_fetchvertex with a mesh-level reference model.
module tb_tmu2_fetchvertex;
  import tmu2_pkg::*;

  typedef struct packed {
    logic [17:0] ax, ay, bx, by, cx, cy, dx, dy;
    logic [11:0] drx, dry;
  } tok_t;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        sys_rst_n, start, busy;
  logic [6:0]  vertex_hlast, vertex_vlast;
  logic [28:0] vertex_adr;
  logic [11:0] dst_hoffset, dst_voffset;
  logic [10:0] dst_squarew, dst_squareh;

  tmu2_fetchvertex_if bus ();

  tmu2_fetchvertex dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .busy         (busy),
    .vertex_hlast (vertex_hlast),
    .vertex_vlast (vertex_vlast),
    .vertex_adr   (vertex_adr),
    .dst_hoffset  (dst_hoffset),
    .dst_voffset  (dst_voffset),
    .dst_squarew  (dst_squarew),
    .dst_squareh  (dst_squareh),
    .bus          (bus)
  );

  int n_cmp = 0, n_err = 0;
  int bus_dly = 0, pipe_dly = 0;
  bit spur_en = 1'b0;
  logic [31:0] mem_seed = 32'd0;

  logic [31:0] rd_q[$];
  tok_t        tok_q[$];
  int busy_total = 0, cyc_total = 0, pstb_total = 0, overlap_total = 0, stab_total = 0;

  tok_t cur_tok;
  assign cur_tok = {bus.ax, bus.ay, bus.bx, bus.by, bus.cx, bus.cy, bus.dx, bus.dy,
                    bus.drx, bus.dry};

  task automatic check(input string tag, input logic [167:0] obs, input logic [167:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory: vertex i holds X = 64*i + seed, Y = 64*i + 1 + seed in the low 18 bits
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    logic [31:0] i, v, r;
    i = (a - {vertex_adr, 3'b000}) >> 3;
    v = (i << 6) + {31'd0, a[2]} + mem_seed;
    r = $urandom;
    return {r[31:18], v[17:0]};
  endfunction

  function automatic logic [17:0] vval(input int r, input int c, input int w);
    logic [31:0] v;
    v = 32'(64 * (r * 128 + c) + w) + mem_seed;
    return v[17:0];
  endfunction

  function automatic logic [31:0] vaddr(input logic [28:0] base, input int r, input int c,
                                        input int w);
    return {base, 3'b000} + 32'((r * 128 + c) * 8 + w * 4);
  endfunction

  function automatic tok_t tok_at(input int i);
    if (i < tok_q.size()) return tok_q[i];
    return '1;
  endfunction

  function automatic logic [31:0] rd_at(input int i);
    if (i < rd_q.size()) return rd_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  int wcnt = 0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      bus.wbm_ack_i = 1'b0;
      wcnt = 0;
    end else if (bus.wbm_ack_i) begin
      bus.wbm_ack_i = 1'b0;
    end else if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
      if (wcnt >= bus_dly) begin
        bus.wbm_dat_i = mem_data(bus.wbm_adr_o);
        bus.wbm_ack_i = 1'b1;
        rd_q.push_back(bus.wbm_adr_o);
        wcnt = 0;
      end else wcnt++;
    end
  end

  int pwait = 0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      bus.pipe_ack_i = 1'b0;
      pwait = 0;
    end else if (bus.pipe_ack_i) begin
      bus.pipe_ack_i = 1'b0;
    end else if (bus.pipe_stb_o) begin
      if (pwait >= pipe_dly) begin
        bus.pipe_ack_i = 1'b1;
        tok_q.push_back(cur_tok);
        pwait = 0;
      end else pwait++;
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      bus.pipe_ack_i = 1'b1;
    end
  end

  tok_t held;
  bit   prev_pstb = 1'b0;
  always @(negedge sys_clk) begin
    if (busy) busy_total++;
    if (bus.wbm_cyc_o) cyc_total++;
    if (bus.pipe_stb_o) pstb_total++;
    if (bus.wbm_cyc_o && bus.pipe_stb_o) overlap_total++;
    if (bus.pipe_stb_o && prev_pstb && cur_tok !== held) stab_total++;
    held = cur_tok;
    prev_pstb = bus.pipe_stb_o;
  end

  task automatic run_mesh(input string name, input int h, input int v, input logic [28:0] base,
                          input logic [11:0] hoff, input logic [11:0] voff,
                          input logic [10:0] sw, input logic [10:0] sh);
    tok_t        exp_tok[$];
    logic [31:0] exp_rd[$];
    tok_t        t;
    logic [31:0] tmp;
    int rd0, tk0, ovl0, stab0;
    bit done, reuse;
`ifdef TMU2_FETCHVERTEX_REUSE_EN
    reuse = 1'b1;
`else
    reuse = 1'b0;
`endif
    for (int r = 0; r < v; r++)
      for (int c = 0; c < h; c++) begin
        t.ax = vval(r, c, 0);     t.ay = vval(r, c, 1);
        t.bx = vval(r, c + 1, 0); t.by = vval(r, c + 1, 1);
        t.cx = vval(r + 1, c, 0); t.cy = vval(r + 1, c, 1);
        t.dx = vval(r + 1, c + 1, 0); t.dy = vval(r + 1, c + 1, 1);
        tmp = {20'd0, hoff} + 32'(c * int'(sw)); t.drx = tmp[11:0];
        tmp = {20'd0, voff} + 32'(r * int'(sh)); t.dry = tmp[11:0];
        exp_tok.push_back(t);
        for (int k = 0; k < 4; k++)
          if (!(reuse && c > 0 && (k % 2) == 0))
            for (int w = 0; w < 2; w++) exp_rd.push_back(vaddr(base, r + k / 2, c + k % 2, w));
      end

    @(negedge sys_clk);
    vertex_hlast = 7'(h); vertex_vlast = 7'(v); vertex_adr = base;
    dst_hoffset = hoff; dst_voffset = voff; dst_squarew = sw; dst_squareh = sh;
    rd0 = rd_q.size(); tk0 = tok_q.size(); ovl0 = overlap_total; stab0 = stab_total;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin done = 1'b1; break; end
      @(negedge sys_clk);
    end
    check({name, " done"}, done, 1);
    check({name, " ntok"}, tok_q.size() - tk0, exp_tok.size());
    foreach (exp_tok[i]) check($sformatf("%s tok%0d", name, i), tok_at(tk0 + i), exp_tok[i]);
    check({name, " nrd"}, rd_q.size() - rd0, exp_rd.size());
    foreach (exp_rd[i]) check($sformatf("%s rd%0d", name, i), rd_at(rd0 + i), exp_rd[i]);
    check({name, " stable"}, stab_total - stab0, 0);
    check({name, " no_bus_in_output"}, overlap_total - ovl0, 0);
    if (!done) begin
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
    end
  endtask

  tok_t t1;
  logic [31:0] exp_single [8];
  logic [23:0] exp_dr [4];
  logic [28:0] b;
  int t0, r0, b0, c0, p0;
  bit found;

  initial begin
    sys_rst_n = 1'b0; start = 1'b0;
    vertex_hlast = '0; vertex_vlast = '0; vertex_adr = '0;
    dst_hoffset = '0; dst_voffset = '0; dst_squarew = '0; dst_squareh = '0;
    #12;
    check("reset ctl", {busy, bus.wbm_cyc_o, bus.wbm_stb_o, bus.pipe_stb_o}, 0);
    check("reset adr", bus.wbm_adr_o, 0);
    check("reset cti", bus.wbm_cti_o, 0);
    check("reset tok", cur_tok, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Single square, fixed pattern
    t0 = tok_q.size(); r0 = rd_q.size();
    run_mesh("single", 1, 1, 29'h100, 12'd5, 12'd7, 11'd16, 11'd8);
    exp_single = '{32'h800, 32'h804, 32'h808, 32'h80C, 32'hC00, 32'hC04, 32'hC08, 32'hC0C};
    foreach (exp_single[i]) check($sformatf("single adr%0d", i), rd_at(r0 + i), exp_single[i]);
    t1 = '{ax: 18'd0, ay: 18'd1, bx: 18'd64, by: 18'd65, cx: 18'd8192, cy: 18'd8193,
           dx: 18'd8256, dy: 18'd8257, drx: 12'd5, dry: 12'd7};
    check("single token", tok_at(t0), t1);
    check("single busy low", busy, 0);

    // 2x2 mesh, negative horizontal offset
    t0 = tok_q.size();
    run_mesh("mesh2x2", 2, 2, 29'h0004_0000, 12'hFF8, 12'd0, 11'd16, 11'd8);
    exp_dr = '{{12'hFF8, 12'd0}, {12'd8, 12'd0}, {12'hFF8, 12'd8}, {12'd8, 12'd8}};
    foreach (exp_dr[i]) begin
      t1 = tok_at(t0 + i);
      check($sformatf("mesh2x2 dr%0d", i), {t1.drx, t1.dry}, exp_dr[i]);
    end

    // Empty meshes
    b0 = busy_total; c0 = cyc_total; p0 = pstb_total;
    run_mesh("empty_h", 0, 3, 29'h55, 12'd1, 12'd2, 11'd3, 11'd4);
    check("empty_h busy cycles", busy_total - b0, 1);
    check("empty_h cyc", cyc_total - c0, 0);
    check("empty_h pstb", pstb_total - p0, 0);
    b0 = busy_total; c0 = cyc_total; p0 = pstb_total;
    run_mesh("empty_v", 3, 0, 29'h55, 12'd1, 12'd2, 11'd3, 11'd4);
    check("empty_v busy cycles", busy_total - b0, 1);
    check("empty_v cyc", cyc_total - c0, 0);
    check("empty_v pstb", pstb_total - p0, 0);

    // Back-pressure and bus wait states
    bus_dly = 3; pipe_dly = 10; mem_seed = $urandom;
    run_mesh("backpressure", 2, 2, 29'($urandom), 12'($urandom), 12'($urandom),
             11'($urandom), 11'($urandom));

    // Reset during the third read
    b = 29'h0123_4560;
    @(negedge sys_clk);
    vertex_hlast = 7'd2; vertex_vlast = 7'd2; vertex_adr = b;
    r0 = rd_q.size();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (rd_q.size() - r0 == 2 && bus.wbm_cyc_o && bus.wbm_adr_o == vaddr(b, 0, 1, 0)) begin
        found = 1'b1; break;
      end
      @(negedge sys_clk);
    end
    check("third read reached", found, 1);
    sys_rst_n = 1'b0;
    #1;
    check("async reset ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, busy, bus.pipe_stb_o}, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bus_dly = 0; pipe_dly = 0;
    run_mesh("after_reset", 2, 2, b, 12'd3, 12'd4, 11'd5, 11'd6);

    // Read count for a 2x1 mesh
    r0 = rd_q.size();
    run_mesh("reuse2x1", 2, 1, 29'h200, 12'd0, 12'd0, 11'd32, 11'd32);
`ifdef TMU2_FETCHVERTEX_REUSE_EN
    check("reuse2x1 read count", rd_q.size() - r0, 12);
`else
    check("reuse2x1 read count", rd_q.size() - r0, 16);
`endif

    // Randomized meshes with spurious pipe acks
    spur_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      bus_dly = $urandom_range(0, 2); pipe_dly = $urandom_range(0, 3); mem_seed = $urandom;
      run_mesh($sformatf("rnd%0d", it), $urandom_range(1, 4), $urandom_range(1, 3),
               29'($urandom), 12'($urandom), 12'($urandom), 11'($urandom), 11'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
